// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of the hazard controller's decode/execute status inputs and its
// pipeline enable/flush outputs.
//   master : the datapath side; drives ID/EX status and receives the controls
//   slave  : the hazard controller; reads status and drives the controls
// Signals:
//   id_rs1, id_rs2, id_rs2_use, id_is_mul, id_jump, id_is_jr, id_hlt : ID stage
//   ex_mem_rd, ex_rd, ex_branch_taken                                  : EX stage
//   pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble : controls
//   mul_busy, halted                                                   : status
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs2_use;
  logic              id_is_mul;
  logic              id_jump;
  logic              id_is_jr;
  logic              id_hlt;
  logic              ex_mem_rd;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_branch_taken;
  logic              pc_en;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_ex_en;
  logic              id_ex_flush;
  logic              ex_mem_bubble;
  logic              mul_busy;
  logic              halted;

  modport master (
    output id_rs1, id_rs2, id_rs2_use, id_is_mul, id_jump, id_is_jr, id_hlt,
           ex_mem_rd, ex_rd, ex_branch_taken,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble,
           mul_busy, halted
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs2_use, id_is_mul, id_jump, id_is_jr, id_hlt,
           ex_mem_rd, ex_rd, ex_branch_taken,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble,
           mul_busy, halted
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage core. Handles the load-use
// interlock, branch/jump squash, multi-cycle MUL occupancy of EX and the
// HLT drain-to-halt sequence.
// Ports:
//   clk  : core clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : slave side of pipeline_hazard_ctrl_if (ID/EX status in, controls out)
// Parameters:
//   MUL_LAT      : cycles a MUL occupies EX (>=1)
//   DRAIN_CYCLES : cycles after HLT leaves ID before halted asserts (>=1)
//   REG_AW       : register-index width
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT      = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int REG_AW       = 5
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int CNT_MAX = (MUL_LAT > DRAIN_CYCLES) ? MUL_LAT : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {
    RUN,
    MUL_WAIT,
    DRAIN,
    HALTED
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic load_use;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_bubble, mul_busy, halted;

  // A load in EX whose destination feeds the ID instruction must hold ID for
  // one cycle; r0 is hard-wired so it can never be a real dependency.
  assign load_use = bus.ex_mem_rd && (bus.ex_rd != {REG_AW{1'b0}}) &&
                    ((bus.ex_rd == bus.id_rs1) ||
                     (bus.id_rs2_use && (bus.ex_rd == bus.id_rs2)));

  // State and countdown register; reset always lands in RUN with a clear count
  // so an interrupted MUL wait or drain leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode. Outputs depend on the current state and
  // the live ID/EX inputs, so a stall takes effect in the same cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mul_busy      = 1'b0;
    halted        = 1'b0;

    if (rst) begin
      if_id_flush   = 1'b1;
      id_ex_en      = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
          id_ex_en = 1'b1;
          // A taken branch makes the ID instruction wrong-path, so nothing it
          // asks for (stall, jump, halt, MUL) is honoured this cycle.
          if (bus.ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (bus.id_jump || bus.id_is_jr) begin
            if_id_flush = 1'b1;
          end else if (bus.id_hlt) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            state_d     = DRAIN;
            cnt_d       = CNT_W'(DRAIN_CYCLES - 1);
          end else if (bus.id_is_mul && (MUL_LAT > 1)) begin
            state_d = MUL_WAIT;
            cnt_d   = CNT_W'(MUL_LAT - 2);
          end
        end
        MUL_WAIT: begin
          ex_mem_bubble = 1'b1;
          mul_busy      = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        DRAIN: begin
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_en    = 1'b1;
          id_ex_flush = 1'b1;
          if (cnt_q == '0) state_d = HALTED;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        HALTED: begin
          ex_mem_bubble = 1'b1;
          halted        = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign bus.pc_en         = pc_en;
  assign bus.if_id_en      = if_id_en;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_en      = id_ex_en;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.ex_mem_bubble = ex_mem_bubble;
  assign bus.mul_busy      = mul_busy;
  assign bus.halted        = halted;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances share one
// stimulus stream: one with MUL_LAT=4 and one with MUL_LAT=1. A cycle-count
// reference model predicts every output vector.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, ex_rd;
  logic       rs2_use, is_mul, jump, is_jr, hlt, mem_rd, br;

  int total = 0;
  int bad   = 0;

  // Reference state per instance: remaining MUL busy cycles, remaining drain
  // cycles, and whether the core has halted.
  int mul_left   [2];
  int drain_left [2];
  bit m_halted   [2];
  int lat        [2] = '{4, 1};
  localparam int DRAIN = 3;

  // Stimulus record: {rst, rs1, rs2, rs2_use, mul, jump, jr, hlt, mem_rd, ex_rd, br}
  typedef logic [22:0] stim_t;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_AW(5)) bus4 ();
  pipeline_hazard_ctrl_if #(.REG_AW(5)) bus1 ();

  assign bus4.id_rs1 = rs1;          assign bus1.id_rs1 = rs1;
  assign bus4.id_rs2 = rs2;          assign bus1.id_rs2 = rs2;
  assign bus4.id_rs2_use = rs2_use;  assign bus1.id_rs2_use = rs2_use;
  assign bus4.id_is_mul = is_mul;    assign bus1.id_is_mul = is_mul;
  assign bus4.id_jump = jump;        assign bus1.id_jump = jump;
  assign bus4.id_is_jr = is_jr;      assign bus1.id_is_jr = is_jr;
  assign bus4.id_hlt = hlt;          assign bus1.id_hlt = hlt;
  assign bus4.ex_mem_rd = mem_rd;    assign bus1.ex_mem_rd = mem_rd;
  assign bus4.ex_rd = ex_rd;         assign bus1.ex_rd = ex_rd;
  assign bus4.ex_branch_taken = br;  assign bus1.ex_branch_taken = br;

  pipeline_hazard_ctrl #(.MUL_LAT(4), .DRAIN_CYCLES(3), .REG_AW(5)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );
  pipeline_hazard_ctrl #(.MUL_LAT(1), .DRAIN_CYCLES(3), .REG_AW(5)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  // Output vectors: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
  //                  ex_mem_bubble, mul_busy, halted}
  wire [7:0] out4 = {bus4.pc_en, bus4.if_id_en, bus4.if_id_flush, bus4.id_ex_en,
                     bus4.id_ex_flush, bus4.ex_mem_bubble, bus4.mul_busy, bus4.halted};
  wire [7:0] out1 = {bus1.pc_en, bus1.if_id_en, bus1.if_id_flush, bus1.id_ex_en,
                     bus1.id_ex_flush, bus1.ex_mem_bubble, bus1.mul_busy, bus1.halted};

  function automatic stim_t mk(input bit r, input int a1, input int a2, input bit u,
                               input bit m, input bit j, input bit jr, input bit h,
                               input bit mr, input int rd, input bit b);
    return {r, a1[4:0], a2[4:0], u, m, j, jr, h, mr, rd[4:0], b};
  endfunction

  function automatic stim_t rand_stim(input bit allow_rst);
    return mk(allow_rst && ($urandom_range(0, 49) == 0),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0,
              int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
  endfunction

  task automatic apply_stim(input stim_t s);
    {rst, rs1, rs2, rs2_use, is_mul, jump, is_jr, hlt, mem_rd, ex_rd, br} = s;
  endtask

  function automatic logic [7:0] exp_out(input int k);
    int  dest;
    bit  lu;
    dest = int'(ex_rd);
    lu   = mem_rd && (dest != 0) &&
           ((dest == int'(rs1)) || (rs2_use && (dest == int'(rs2))));
    if (rst)               return 8'b0011_1100;
    if (m_halted[k])       return 8'b0000_0101;
    if (drain_left[k] > 0) return 8'b0111_1000;
    if (mul_left[k] > 0)   return 8'b0000_0110;
    if (br)                return 8'b1111_1000;
    if (lu)                return 8'b0001_1000;
    if (jump || is_jr)     return 8'b1111_0000;
    if (hlt)               return 8'b0111_0000;
    return 8'b1101_0000;
  endfunction

  // Advance the reference model by one clock, then move to just after the edge.
  task automatic advance();
    int  dest;
    bit  lu;
    dest = int'(ex_rd);
    lu   = mem_rd && (dest != 0) &&
           ((dest == int'(rs1)) || (rs2_use && (dest == int'(rs2))));
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mul_left[k] = 0; drain_left[k] = 0; m_halted[k] = 1'b0;
      end else if (m_halted[k]) begin
      end else if (drain_left[k] > 0) begin
        drain_left[k]--;
        if (drain_left[k] == 0) m_halted[k] = 1'b1;
      end else if (mul_left[k] > 0) begin
        mul_left[k]--;
      end else if (!br && !lu && !jump && !is_jr) begin
        if (hlt)         drain_left[k] = DRAIN;
        else if (is_mul) mul_left[k] = lat[k] - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t q[$];
    q.push_back(mk(1, 3, 3, 1, 1, 1, 1, 1, 1, 3, 1));
    q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply_stim(q[i]);
      @(negedge clk);
      total++;
      if (out4 !== exp_out(0)) begin
        bad++; $display("[TB] FAIL reset[%0d] lat4 got=%b want=%b", i, out4, exp_out(0));
      end
      total++;
      if (out1 !== exp_out(1)) begin
        bad++; $display("[TB] FAIL reset[%0d] lat1 got=%b want=%b", i, out1, exp_out(1));
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    stim_t q[$];
    q.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 1, 3, 0));
    q.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    q.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 1, 3, 0));
    q.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 1, 3, 0));
    q.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 3, 0));
    foreach (q[i]) begin
      apply_stim(q[i]);
      @(negedge clk);
      total++;
      if (out4 !== exp_out(0)) begin
        bad++; $display("[TB] FAIL load_use[%0d] got=%b want=%b", i, out4, exp_out(0));
      end
      advance();
    end
  endtask

  task automatic test_branch();
    stim_t q[$];
    q.push_back(mk(0, 3, 0, 0, 1, 1, 0, 1, 1, 3, 1));
    for (int i = 0; i < 5; i++) q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply_stim(q[i]);
      @(negedge clk);
      total++;
      if (out4 !== exp_out(0) || bus4.halted !== 1'b0) begin
        bad++; $display("[TB] FAIL branch[%0d] got=%b want=%b", i, out4, exp_out(0));
      end
      advance();
    end
  endtask

  task automatic test_mul();
    stim_t q[$];
    q.push_back(mk(0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 1));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply_stim(q[i]);
      @(negedge clk);
      total++;
      if (out4 !== exp_out(0)) begin
        bad++; $display("[TB] FAIL mul[%0d] lat4 got=%b want=%b", i, out4, exp_out(0));
      end
      total++;
      if (out1 !== exp_out(1) || bus1.mul_busy !== 1'b0) begin
        bad++; $display("[TB] FAIL mul[%0d] lat1 got=%b want=%b", i, out1, exp_out(1));
      end
      advance();
    end
  endtask

  task automatic test_jump();
    stim_t q[$];
    q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 5, 0, 0, 0, 0, 1, 0, 1, 5, 0));
    q.push_back(mk(0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply_stim(q[i]);
      @(negedge clk);
      total++;
      if (out4 !== exp_out(0)) begin
        bad++; $display("[TB] FAIL jump[%0d] got=%b want=%b", i, out4, exp_out(0));
      end
      advance();
    end
  endtask

  task automatic test_halt();
    stim_t q[$];
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 26; i++) q.push_back(rand_stim(1'b0));
    foreach (q[i]) begin
      apply_stim(q[i]);
      @(negedge clk);
      total++;
      if (out4 !== exp_out(0) || (i >= 4 && bus4.halted !== 1'b1)) begin
        bad++; $display("[TB] FAIL halt[%0d] got=%b want=%b", i, out4, exp_out(0));
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_op();
    stim_t q[$];
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply_stim(q[i]);
      @(negedge clk);
      total++;
      if (out4 !== exp_out(0)) begin
        bad++; $display("[TB] FAIL reset_mid[%0d] got=%b want=%b", i, out4, exp_out(0));
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply_stim(rand_stim(1'b1));
      @(negedge clk);
      total++;
      if (out4 !== exp_out(0)) begin
        bad++; $display("[TB] FAIL random[%0d] lat4 got=%b want=%b", i, out4, exp_out(0));
      end
      total++;
      if (out1 !== exp_out(1)) begin
        bad++; $display("[TB] FAIL random[%0d] lat1 got=%b want=%b", i, out1, exp_out(1));
      end
      advance();
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mul_left[k] = 0; drain_left[k] = 0; m_halted[k] = 1'b0;
    end
    apply_stim(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_load_use();
    test_branch();
    test_mul();
    test_jump();
    test_reset_mid_op();
    test_halt();
    apply_stim(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    advance();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
